// File: rtl/sdr_cmd_arb_if.sv
// ============================================================================
// sdr_cmd_arb_if : request/done/grant bundle of the SDRAM command arbiter, rev 1.0
// ============================================================================
`default_nettype none

interface sdr_cmd_arb_if;
  logic       init_done;
  logic       wr_req;
  logic       rd_req;
  logic       wr_done;
  logic       rd_done;
  logic       ref_done;
  logic       wr_grant;
  logic       rd_grant;
  logic       ref_grant;
  logic [2:0] arb_state;
  logic [3:0] ref_pend;
  logic       ref_ovf;

  // arbiter side
  modport slave (
    input  init_done, wr_req, rd_req, wr_done, rd_done, ref_done,
    output wr_grant, rd_grant, ref_grant, arb_state, ref_pend, ref_ovf
  );

  // user ports and engines side
  modport master (
    output init_done, wr_req, rd_req, wr_done, rd_done, ref_done,
    input  wr_grant, rd_grant, ref_grant, arb_state, ref_pend, ref_ovf
  );
endinterface

`default_nettype wire

// File: rtl/sdr_cmd_arb.sv
// ============================================================================
// sdr_cmd_arb : SDRAM engine arbiter with refresh timer and pending counter, rev 1.0
// ============================================================================
`default_nettype none

module sdr_cmd_arb #(
  parameter int REF_INTERVAL = 1300,
  parameter int REF_URGENT   = 4,
  parameter int REF_MAX      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  sdr_cmd_arb_if.slave arb_io
);

  localparam int            TW          = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [TW-1:0] TMR_LAST    = TW'(REF_INTERVAL - 1);
  localparam logic [3:0]    PEND_URGENT = 4'(REF_URGENT);
  localparam logic [3:0]    PEND_MAX    = 4'(REF_MAX);

  typedef enum logic [2:0] {
    ST_WAIT_INIT = 3'd0,
    ST_IDLE      = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ      = 3'd3,
    ST_REFRESH   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          last_rd_q, last_rd_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [3:0]    pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic          wr_gnt_q, wr_gnt_d;
  logic          rd_gnt_q, rd_gnt_d;
  logic          ref_gnt_q, ref_gnt_d;
  logic          tick;
  logic          ref_dec;

  always_comb begin
    tmr_d = tmr_q;
    tick  = 1'b0;
    if (state_q == ST_WAIT_INIT) begin
      tmr_d = '0;
    end else if (tmr_q == TMR_LAST) begin
      tmr_d = '0;
      tick  = 1'b1;
    end else begin
      tmr_d = tmr_q + TW'(1);
    end
  end

  // A tick and a completed refresh in the same cycle cancel out.
  always_comb begin
    ref_dec = (state_q == ST_REFRESH) && arb_io.ref_done;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    if (tick && (pend_q == PEND_MAX)) begin
      ovf_d = 1'b1;
    end
    if (tick && !ref_dec) begin
      if (pend_q < PEND_MAX) begin
        pend_d = pend_q + 4'd1;
      end
    end else if (!tick && ref_dec) begin
      if (pend_q != 4'd0) begin
        pend_d = pend_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    case (state_q)
      ST_WAIT_INIT: begin
        if (arb_io.init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (pend_q >= PEND_URGENT) begin
          state_d = ST_REFRESH;
        end else if (arb_io.wr_req && arb_io.rd_req) begin
          state_d = last_rd_q ? ST_WRITE : ST_READ;
        end else if (arb_io.wr_req) begin
          state_d = ST_WRITE;
        end else if (arb_io.rd_req) begin
          state_d = ST_READ;
        end else if (pend_q != 4'd0) begin
          state_d = ST_REFRESH;
        end
      end
      ST_WRITE: begin
        if (arb_io.wr_done) begin
          state_d   = ST_IDLE;
          last_rd_d = 1'b0;
        end
      end
      ST_READ: begin
        if (arb_io.rd_done) begin
          state_d   = ST_IDLE;
          last_rd_d = 1'b1;
        end
      end
      ST_REFRESH: begin
        if (arb_io.ref_done) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT_INIT;
    endcase

    // Grants trail the state by one cycle and drop right after the done pulse.
    wr_gnt_d  = (state_q == ST_WRITE)   && !arb_io.wr_done;
    rd_gnt_d  = (state_q == ST_READ)    && !arb_io.rd_done;
    ref_gnt_d = (state_q == ST_REFRESH) && !arb_io.ref_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT_INIT;
      last_rd_q <= 1'b1;
      tmr_q     <= '0;
      pend_q    <= 4'd0;
      ovf_q     <= 1'b0;
      wr_gnt_q  <= 1'b0;
      rd_gnt_q  <= 1'b0;
      ref_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      tmr_q     <= tmr_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      wr_gnt_q  <= wr_gnt_d;
      rd_gnt_q  <= rd_gnt_d;
      ref_gnt_q <= ref_gnt_d;
    end
  end

  assign arb_io.wr_grant  = wr_gnt_q;
  assign arb_io.rd_grant  = rd_gnt_q;
  assign arb_io.ref_grant = ref_gnt_q;
  assign arb_io.arb_state = state_q;
  assign arb_io.ref_pend  = pend_q;
  assign arb_io.ref_ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sdr_cmd_arb.sv
// ============================================================================
// tb_sdr_cmd_arb : directed self-checking bench for sdr_cmd_arb, rev 1.0
// ============================================================================
`default_nettype none

module tb_sdr_cmd_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  sdr_cmd_arb_if arb_if ();

  sdr_cmd_arb #(
    .REF_INTERVAL(16),
    .REF_URGENT  (4),
    .REF_MAX     (8)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb_io(arb_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Waits for a grant, checks which engine got it, then optionally returns done after hold cycles.
  task automatic serve(input int exp_kind, input int hold, input int exp_pend);
    int gap;
    int kind;
    bit found;
    gap   = 1;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (arb_if.wr_grant || arb_if.rd_grant || arb_if.ref_grant) begin
        found = 1'b1;
        break;
      end
      gap++;
    end
    if (!found) begin
      chk("grant_wait", 0, 1);
      return;
    end
    kind = arb_if.wr_grant ? 0 : (arb_if.rd_grant ? 1 : 2);
    chk("grant_kind", kind, exp_kind);
    chk("grant_gap", gap >= 2, 1);
    if (exp_pend >= 0) chk("grant_pend", arb_if.ref_pend, exp_pend);
    if (hold > 0) begin
      repeat (hold - 1) @(negedge clk);
      case (kind)
        0:       arb_if.wr_done = 1'b1;
        1:       arb_if.rd_done = 1'b1;
        default: arb_if.ref_done = 1'b1;
      endcase
      @(negedge clk);
      arb_if.wr_done  = 1'b0;
      arb_if.rd_done  = 1'b0;
      arb_if.ref_done = 1'b0;
      chk("grant_drop", {arb_if.wr_grant, arb_if.rd_grant, arb_if.ref_grant}, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("onehot", (int'(arb_if.wr_grant) + int'(arb_if.rd_grant) + int'(arb_if.ref_grant)) <= 1, 1);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    bit found;
    rst_n            = 1'b0;
    arb_if.init_done = 1'b0;
    arb_if.wr_req    = 1'b0;
    arb_if.rd_req    = 1'b0;
    arb_if.wr_done   = 1'b0;
    arb_if.rd_done   = 1'b0;
    arb_if.ref_done  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_state", arb_if.arb_state, 0);
    chk("rst_grants", {arb_if.wr_grant, arb_if.rd_grant, arb_if.ref_grant}, 0);
    chk("rst_pend", arb_if.ref_pend, 0);
    chk("rst_ovf", arb_if.ref_ovf, 0);
    rst_n = 1'b1;

    // Init gating: no timer, no grants until init_done.
    repeat (50) @(negedge clk);
    chk("init_hold_state", arb_if.arb_state, 0);
    chk("init_hold_grants", {arb_if.wr_grant, arb_if.rd_grant, arb_if.ref_grant}, 0);
    chk("init_hold_pend", arb_if.ref_pend, 0);
    arb_if.init_done = 1'b1;
    @(negedge clk);
    chk("init_idle", arb_if.arb_state, 1);
    repeat (15) @(negedge clk);
    chk("pre_tick_pend", arb_if.ref_pend, 0);
    @(negedge clk);
    chk("first_tick_pend", arb_if.ref_pend, 1);
    chk("first_tick_state", arb_if.arb_state, 1);

    // Opportunistic refresh.
    @(negedge clk);
    chk("opp_ref_state", arb_if.arb_state, 4);
    chk("opp_ref_grant_lag", arb_if.ref_grant, 0);
    @(negedge clk);
    chk("opp_ref_grant", arb_if.ref_grant, 1);
    arb_if.ref_done = 1'b1;
    @(negedge clk);
    arb_if.ref_done = 1'b0;
    chk("opp_ref_idle", arb_if.arb_state, 1);
    chk("opp_ref_pend", arb_if.ref_pend, 0);
    chk("opp_ref_drop", arb_if.ref_grant, 0);

    // Round-robin under continuous traffic until refresh becomes urgent.
    arb_if.wr_req = 1'b1;
    arb_if.rd_req = 1'b1;
    for (int i = 0; i < 9; i++) serve(i % 2, 5, -1);
    serve(2, 5, 4);
    chk("urgent_ref_pend", arb_if.ref_pend, 3);
    serve(1, 5, -1);
    arb_if.rd_req = 1'b0;
    serve(2, 5, 4);
    serve(0, 0, -1);

    // Saturation while the write engine withholds done.
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (arb_if.ref_pend == 4'd8) begin
        found = 1'b1;
        break;
      end
    end
    chk("sat_reach", found, 1);
    repeat (15) @(negedge clk);
    chk("sat_pend", arb_if.ref_pend, 8);
    chk("sat_ovf_pre", arb_if.ref_ovf, 0);
    @(negedge clk);
    chk("sat_ovf", arb_if.ref_ovf, 1);
    chk("sat_pend_hold", arb_if.ref_pend, 8);
    chk("sat_wr_state", arb_if.arb_state, 2);
    chk("sat_wr_grant", arb_if.wr_grant, 1);

    // Done pulses of other engines are ignored.
    arb_if.rd_done  = 1'b1;
    arb_if.ref_done = 1'b1;
    @(negedge clk);
    arb_if.rd_done  = 1'b0;
    arb_if.ref_done = 1'b0;
    chk("stray_state", arb_if.arb_state, 2);
    chk("stray_grant", arb_if.wr_grant, 1);
    chk("stray_pend", arb_if.ref_pend, 8);
    arb_if.wr_done = 1'b1;
    arb_if.wr_req  = 1'b0;
    @(negedge clk);
    arb_if.wr_done = 1'b0;
    chk("wr_end_state", arb_if.arb_state, 1);
    chk("wr_end_grant", arb_if.wr_grant, 0);

    // ref_done lands on a tick edge.
    repeat (13) @(negedge clk);
    chk("tick_done_grant", arb_if.ref_grant, 1);
    chk("tick_done_pre", arb_if.ref_pend, 8);
    arb_if.ref_done = 1'b1;
    @(negedge clk);
    arb_if.ref_done = 1'b0;
    chk("tick_done_pend", arb_if.ref_pend, 8);
    chk("tick_done_state", arb_if.arb_state, 1);
    chk("tick_done_ovf", arb_if.ref_ovf, 1);

    // Asynchronous reset between edges clears counters and sticky flag.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", arb_if.arb_state, 0);
    chk("arst_pend", arb_if.ref_pend, 0);
    chk("arst_ovf", arb_if.ref_ovf, 0);
    chk("arst_grants", {arb_if.wr_grant, arb_if.rd_grant, arb_if.ref_grant}, 0);

    // After reset a tie goes to write; then reset mid-WRITE.
    arb_if.wr_req = 1'b1;
    arb_if.rd_req = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    serve(0, 0, -1);
    #2 rst_n = 1'b0;
    #1;
    chk("wr_rst_grants", {arb_if.wr_grant, arb_if.rd_grant, arb_if.ref_grant}, 0);
    chk("wr_rst_state", arb_if.arb_state, 0);
    chk("wr_rst_pend", arb_if.ref_pend, 0);

    // Timer restarts from zero after reset.
    arb_if.wr_req = 1'b0;
    arb_if.rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rerun_idle", arb_if.arb_state, 1);
    repeat (15) @(negedge clk);
    chk("rerun_pre_tick", arb_if.ref_pend, 0);
    @(negedge clk);
    chk("rerun_tick", arb_if.ref_pend, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
